encoder_out_reader: RTL

ENCODER_OUT_READER -- requirements
Module: encoder_out_reader

---
 rtl/transformer_pkg.sv | 14 +
 rtl/enc_buf_ram.sv | 31 +++
 rtl/encoder_out_reader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/transformer_pkg.sv
// Shared types and default dimensions for the transformer encoder datapath.
package transformer_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_N_TOKENS = 197;
    localparam int DEF_D_MODEL  = 192;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } reader_state_t;

endpackage

// File: rtl/enc_buf_ram.sv
// Single-write, single-registered-read buffer holding one encoder output block.
module enc_buf_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately unreset; a read in the same cycle as a write returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/encoder_out_reader.sv
// Captures a row-major [N_TOKENS x D_MODEL] encoder output block and serves
// single-cycle-latency random reads once the block is complete.
module encoder_out_reader
    import transformer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int N_TOKENS = DEF_N_TOKENS,
    parameter int D_MODEL  = DEF_D_MODEL
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        init,
    output logic                        ready,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            input_block,
    output logic                        done,
    input  logic                        rd_en,
    input  logic [$clog2(N_TOKENS)-1:0] rd_row,
    input  logic [$clog2(D_MODEL)-1:0]  rd_col,
    output logic                        rd_valid,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_err
);

    localparam int ROW_W  = $clog2(N_TOKENS);
    localparam int COL_W  = $clog2(D_MODEL);
    localparam int DEPTH  = N_TOKENS * D_MODEL;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_TOKENS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(D_MODEL - 1);

    function automatic logic [ADDR_W-1:0] buf_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
        return ADDR_W'(32'(r) * 32'(D_MODEL) + 32'(c));
    endfunction

    reader_state_t      state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_err_q, rd_err_d;
    logic               rd_ok_q, rd_ok_d;

    logic               wr_en;
    logic               rd_hit;
    logic [WIDTH-1:0]   ram_rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FULL: begin
                if (init) begin
                    state_d = ST_CAPTURE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_CAPTURE: begin
                // init is intentionally ignored here so a capture always completes.
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            state_d = ST_FULL;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reads are judged against the state at request time, so a read issued
    // alongside init in FULL still sees the completed block.
    always_comb begin
        rd_hit     = (state_q == ST_FULL) && (int'(rd_row) < N_TOKENS) &&
                     (int'(rd_col) < D_MODEL);
        rd_valid_d = rd_en;
        rd_err_d   = rd_en && !rd_hit;
        rd_ok_d    = rd_en && rd_hit;
    end

    enc_buf_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (buf_addr(row_q, col_q)),
        .wr_data (input_block),
        .rd_en   (rd_en && rd_hit),
        .rd_addr (buf_addr(rd_row, rd_col)),
        .rd_data (ram_rd_data)
    );

    assign in_ready = (state_q == ST_CAPTURE);
    assign ready    = (state_q != ST_CAPTURE);
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_ok_q ? ram_rd_data : '0;

endmodule
